fnv1a_hasher_fsm: RTL and testbench
===================================

# fnv1a_hasher_fsm

FNV-1a 32-bit hashing engine in the `system_clk` domain, between the two async FIFOs of the I2C front end. Pops message bytes from the read side of `to_hasher_fifo`, folds each into a running FNV-1a state, and on an end-of-message request pushes the finished 32-bit hash into the write side of `from_hasher_fifo`. The I2C side then streams that hash back to the controller.

## Interface
- `OFFSET_BASIS`, default 32'h811C9DC5: initial hash state.
- `BYTE_COUNT_W`, default 16: width of the byte counter, used only with `HASHER_BYTE_COUNT_EN`.

Ports:
- `system_clk`  in  1  design clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  byte at the head of `to_hasher_fifo` (`rdata`), valid whenever `in_empty`=0.
- `in_empty`  in  1  `to_hasher_fifo` `rempty`.
- `in_inc`  out  1  pop strobe to `to_hasher_fifo` `rinc`.
- `finish`  in  1  single-cycle end-of-message request, already synchronized to `system_clk`.
- `out_data`  out  32  hash word to `from_hasher_fifo` `wdata`.
- `out_full`  in  1  `from_hasher_fifo` `wfull`.
- `out_inc`  out  1  push strobe to `from_hasher_fifo` `winc`.
- `busy`  out  1  high in DRAIN or EMIT.
- `byte_count`  out  `BYTE_COUNT_W`  bytes absorbed in the current message.

## Operation
- Hash arithmetic, all modulo 2^32: next = (hash ^ {24'b0, in_data}) * 32'h01000193.
- The multiply is implemented as a single-cycle shift-add: x + (x<<1) + (x<<4) + (x<<7) + (x<<8) + (x<<24), truncated to 32 bits. No DSP or `*` operator.
- Absorb rule: in ABSORB or DRAIN, with `in_empty`=0, the block drives `in_inc`=1, and `hash` takes the next value in the same edge. Throughput is one byte per cycle.
- `in_inc` is combinational: `in_inc` = (state∈{ABSORB,DRAIN}) & ~`in_empty`. It is never asserted while `in_empty`=1.

State machine:
- ABSORB: reset state.
  - On `finish`=1 (or `pending`=1), go to DRAIN. Clear `pending`.
- DRAIN: keep absorbing while bytes remain.
  - When `in_empty`=1, go to EMIT; `out_data` is loaded with `hash`.
  - `finish` in DRAIN is merged and dropped.
- EMIT: `out_inc` = ~`out_full`.
  - On a cycle with `out_inc`=1, go to ABSORB, set `hash`←`OFFSET_BASIS`, and clear `byte_count`.
  - `finish` in EMIT sets `pending`, so the next message closes immediately after its drain.
  - No bytes are popped in EMIT.

Boundary conditions:
- Empty message (`finish` with no bytes absorbed): emits `OFFSET_BASIS`.
- `out_full` held high: stay in EMIT indefinitely. `out_data` is stable and `out_inc`=0.
- Bytes arriving during EMIT stay in the FIFO and belong to the next message.
- A `finish` in the same cycle as a byte pop in ABSORB: that byte belongs to the closing message.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state=ABSORB, `hash`=`OFFSET_BASIS`, `pending`=0.
  - `out_data`=0, `out_inc`=0, `in_inc`=0, `busy`=0, `byte_count`=0.
- Reset mid-message discards the partial hash. No word is pushed.
- Latency: last byte popped at edge N with `finish` already seen; DRAIN observes `in_empty` at N+1. `out_inc` is first high in cycle N+2 if `out_full`=0.
- `out_inc` is high for exactly one cycle per message. `out_data` is held from entry into EMIT until the push edge.

## Configuration
- `HASHER_BYTE_COUNT_EN` defined:
  - `byte_count` increments on every pop and saturates at all-ones.
  - It clears on the push edge and on reset.
- `HASHER_BYTE_COUNT_EN` undefined: the counter is not built and `byte_count` is tied to 0. Hashing is unaffected.

## Test plan
- Empty message: after reset, pulse `finish` -> one `out_inc`, `out_data`=32'h811C9DC5, `busy` returns to 0.
- Single byte: FIFO holds 8'h61 ("a"), then `finish` -> `out_data`=32'hE40C292C. `byte_count`=1 before the push (with `HASHER_BYTE_COUNT_EN`).
- Back-to-back stream: "foobar" (66 6F 6F 62 61 72) with `in_empty`=0 each cycle -> six consecutive `in_inc` pulses, then `out_data`=32'hBF9CF968.
- Backpressure: hold `out_full`=1 for 10 cycles after "a"+`finish` -> `out_inc`=0 and `out_data` stable throughout; single push on release. Bytes queued meanwhile hash into the next message.
- `finish` during EMIT plus 1 new byte 8'h61 -> first word = previous hash; second word 32'hE40C292C with no further `finish`.
- Async reset asserted mid-"foobar" -> outputs at reset values within the same cycle, no push. A following "a"+`finish` yields 32'hE40C292C.

Source files
------------

// File: rtl/fnv1a_hasher_fsm.sv
// fnv1a_hasher_fsm: FNV-1a 32-bit hashing engine between the I2C front-end FIFOs.
//
// Pops message bytes from to_hasher_fifo, folds each into a running FNV-1a state
// (one byte per cycle), and on an end-of-message request pushes the 32-bit hash
// into from_hasher_fifo.
//
// Optional feature macro: HASHER_BYTE_COUNT_EN builds a saturating per-message
// byte counter; when undefined byte_count is tied to 0.
//
// Ports:
//   system_clk  in   design clock (rising edge)
//   reset       in   asynchronous active-high reset
//   in_data     in   [7:0]  head byte of to_hasher_fifo
//   in_empty    in   to_hasher_fifo empty flag
//   in_inc      out  pop strobe to to_hasher_fifo
//   finish      in   single-cycle end-of-message request
//   out_data    out  [31:0] hash word to from_hasher_fifo
//   out_full    in   from_hasher_fifo full flag
//   out_inc     out  push strobe to from_hasher_fifo
//   busy        out  high while draining or emitting
//   byte_count  out  [BYTE_COUNT_W-1:0] bytes absorbed in current message
module fnv1a_hasher_fsm #(
   parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
   parameter int unsigned BYTE_COUNT_W = 16
) (
   input  logic                    system_clk,
   input  logic                    reset,
   input  logic [7:0]              in_data,
   input  logic                    in_empty,
   output logic                    in_inc,
   input  logic                    finish,
   output logic [31:0]             out_data,
   input  logic                    out_full,
   output logic                    out_inc,
   output logic                    busy,
   output logic [BYTE_COUNT_W-1:0] byte_count
);

   typedef enum logic [1:0] {ABSORB, DRAIN, EMIT} state_t;

   state_t      state, state_next;
   logic [31:0] hash, hash_next;
   logic [31:0] out_data_next;
   logic        pending, pending_next;
   logic [31:0] mix, prod;

   // Multiply by the FNV prime 0x01000193 as a shift-add (bits 24, 8, 7, 4, 1, 0).
   always_comb begin
      mix  = hash ^ {24'h0, in_data};
      prod = mix + (mix << 1) + (mix << 4) + (mix << 7) + (mix << 8) + (mix << 24);
   end

   always_comb begin
      state_next    = state;
      hash_next     = hash;
      pending_next  = pending;
      out_data_next = out_data;
      in_inc        = 1'b0;
      out_inc       = 1'b0;
      busy          = 1'b0;
      unique case (state)
         ABSORB: begin
            in_inc = ~in_empty;
            if (!in_empty) hash_next = prod;
            // A byte popped on the finish edge still belongs to the closing message.
            if (finish || pending) begin
               state_next   = DRAIN;
               pending_next = 1'b0;
            end
         end
         DRAIN: begin
            busy   = 1'b1;
            in_inc = ~in_empty;
            if (!in_empty) begin
               hash_next = prod;
            end else begin
               state_next    = EMIT;
               out_data_next = hash;
            end
         end
         EMIT: begin
            busy    = 1'b1;
            out_inc = ~out_full;
            // A finish here closes the next message as soon as its bytes drain.
            if (finish) pending_next = 1'b1;
            if (!out_full) begin
               state_next = ABSORB;
               hash_next  = OFFSET_BASIS;
            end
         end
         default: state_next = ABSORB;
      endcase
   end

   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         state    <= ABSORB;
         hash     <= OFFSET_BASIS;
         pending  <= 1'b0;
         out_data <= 32'h0;
      end else begin
         state    <= state_next;
         hash     <= hash_next;
         pending  <= pending_next;
         out_data <= out_data_next;
      end
   end

`ifdef HASHER_BYTE_COUNT_EN
   logic [BYTE_COUNT_W-1:0] count;

   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (out_inc) begin
         count <= '0;
      end else if (in_inc && (count != '1)) begin
         count <= count + {{(BYTE_COUNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign byte_count = count;
`else
   assign byte_count = '0;
`endif

endmodule

// File: tb/tb_fnv1a_hasher_fsm.sv
// Testbench for fnv1a_hasher_fsm: FIFO model on both sides, reference FNV-1a
// computed with plain multiplication, scoreboard queue checked by a monitor.
module tb_fnv1a_hasher_fsm;

   logic        system_clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_empty;
   logic        in_inc;
   logic        finish;
   logic [31:0] out_data;
   logic        out_full;
   logic        out_inc;
   logic        busy;
   logic [15:0] byte_count;

   always #5 system_clk = ~system_clk;

   fnv1a_hasher_fsm dut (
      .system_clk (system_clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_empty   (in_empty),
      .in_inc     (in_inc),
      .finish     (finish),
      .out_data   (out_data),
      .out_full   (out_full),
      .out_inc    (out_inc),
      .busy       (busy),
      .byte_count (byte_count)
   );

`ifdef HASHER_BYTE_COUNT_EN
   localparam logic [15:0] ONE_BYTE_COUNT = 16'd1;
`else
   localparam logic [15:0] ONE_BYTE_COUNT = 16'd0;
`endif

   logic [7:0]  fifo_q[$];
   logic [7:0]  msg_q[$];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        last_pop;
   logic        rand_bp = 1'b0;

   function automatic logic [31:0] fnv_ref(input logic [7:0] bytes[$]);
      logic [31:0] h;
      h = 32'h811C9DC5;
      foreach (bytes[i]) h = (h ^ {24'h0, bytes[i]}) * 32'h01000193;
      return h;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic refresh();
      in_empty = (fifo_q.size() == 0);
      in_data  = in_empty ? 8'h00 : fifo_q[0];
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      msg_q.push_back(b);
      refresh();
   endtask

   // One clock: pop decision sampled on the falling edge, FIFO updated after the rise.
   task automatic tick();
      logic pop;
      @(negedge system_clk);
      pop = in_inc;
      @(posedge system_clk);
      #1;
      if (pop) void'(fifo_q.pop_front());
      last_pop = pop;
      finish   = 1'b0;
      if (rand_bp) out_full = ($urandom_range(0, 3) == 0);
      refresh();
   endtask

   task automatic do_finish();
      exp_q.push_back(fnv_ref(msg_q));
      msg_q.delete();
      finish = 1'b1;
      tick();
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!busy && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      check({name, " idle"}, {31'h0, done}, 32'h1);
   endtask

   // Monitor: every push is compared against the oldest expected word.
   always @(negedge system_clk) begin
      if (in_inc && in_empty) begin
         checks++;
         errors++;
         $display("FAIL pop while empty: in_inc=1 in_empty=1");
      end
      if (!reset && out_inc) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected push: got %h, expected no push", out_data);
         end else begin
            check("hash word", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b1;
      finish   = 1'b0;
      out_full = 1'b0;
      refresh();
      #1;
      check("reset out_data", out_data, 32'h0);
      check("reset out_inc", {31'h0, out_inc}, 32'h0);
      check("reset in_inc", {31'h0, in_inc}, 32'h0);
      check("reset busy", {31'h0, busy}, 32'h0);
      check("reset byte_count", {16'h0, byte_count}, 32'h0);
      @(posedge system_clk);
      @(posedge system_clk);
      #1;
      reset = 1'b0;

      // Empty message emits the offset basis.
      do_finish();
      check("empty exp", exp_q[0], 32'h811C9DC5);
      wait_idle("empty");
      check("empty busy", {31'h0, busy}, 32'h0);

      // Single byte "a".
      push_byte(8'h61);
      do_finish();
      check("a byte_count", {16'h0, byte_count}, {16'h0, ONE_BYTE_COUNT});
      wait_idle("single");
      check("a count cleared", {16'h0, byte_count}, 32'h0);
      check("a fifo empty", 32'(fifo_q.size()), 32'h0);

      // "foobar" back to back; finish on the edge that pops the last byte.
      begin
         logic [7:0] foobar[6];
         foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
         foreach (foobar[i]) push_byte(foobar[i]);
         check("foobar ref", fnv_ref(msg_q), 32'hBF9CF968);
         for (int i = 0; i < 5; i++) begin
            tick();
            check("foobar pop", {31'h0, last_pop}, 32'h1);
         end
         do_finish();
         check("foobar last pop", {31'h0, last_pop}, 32'h1);
         wait_idle("foobar");
      end

      // Backpressure: out_full held 10 cycles, bytes queued meanwhile wait.
      out_full = 1'b1;
      push_byte(8'h61);
      do_finish();
      tick();
      for (int i = 0; i < 10; i++) begin
         check("bp out_data", out_data, 32'hE40C292C);
         check("bp out_inc", {31'h0, out_inc}, 32'h0);
         check("bp busy", {31'h0, busy}, 32'h1);
         if (i == 2) begin
            push_byte(8'h78);
            push_byte(8'h79);
         end
         tick();
      end
      check("bp bytes held", 32'(fifo_q.size()), 32'h2);
      out_full = 1'b0;
      wait_idle("bp release");
      do_finish();
      wait_idle("bp next");

      // Finish during EMIT plus one new byte closes the next message by itself.
      out_full = 1'b1;
      for (int i = 0; i < 3; i++) push_byte(8'($urandom));
      do_finish();
      for (int i = 0; i < 6; i++) tick();
      push_byte(8'h61);
      do_finish();
      check("pending byte held", 32'(fifo_q.size()), 32'h1);
      check("pending second exp", exp_q[1], 32'hE40C292C);
      out_full = 1'b0;
      wait_idle("pending");

      // Async reset mid-"foobar": outputs clear immediately, no push.
      begin
         logic [7:0] foobar[6];
         foobar = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
         foreach (foobar[i]) push_byte(foobar[i]);
         for (int i = 0; i < 3; i++) tick();
         #2;
         reset = 1'b1;
         fifo_q.delete();
         msg_q.delete();
         refresh();
         #1;
         check("midreset out_data", out_data, 32'h0);
         check("midreset out_inc", {31'h0, out_inc}, 32'h0);
         check("midreset in_inc", {31'h0, in_inc}, 32'h0);
         check("midreset busy", {31'h0, busy}, 32'h0);
         check("midreset byte_count", {16'h0, byte_count}, 32'h0);
         tick();
         tick();
         #2;
         reset = 1'b0;
         push_byte(8'h61);
         do_finish();
         wait_idle("post reset");
      end

      // Random messages with random gaps and random backpressure.
      rand_bp = 1'b1;
      for (int m = 0; m < 10; m++) begin
         int len;
         len = $urandom_range(0, 9);
         for (int b = 0; b < len; b++) begin
            push_byte(8'($urandom));
            if (b != len - 1) begin
               int gap;
               gap = $urandom_range(0, 2);
               for (int g = 0; g < gap; g++) tick();
            end
         end
         do_finish();
         wait_idle("random");
      end
      rand_bp  = 1'b0;
      out_full = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("scoreboard drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
